dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the far end of the load/store request interface driven by the CPU memory-access pipeline stage.
- Accepts one load or store request at a time over a valid/ready handshake.
- Models a configurable number of wait states, then performs the access on an internal word-organised RAM.
- Returns load data, sign- or zero-extended, or an error flag over a second valid/ready handshake.

Parameters:
ADDR_WIDTH, 12, word-address bits; memory holds 2**ADDR_WIDTH 32-bit words (16 KiB at default)
WAIT_CYCLES, 1, wait states between request accept and response; legal range 0..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  32  load result, right-aligned and extended; 0 for stores and errors
resp_err  output  1  request was misaligned, reserved size, or out of range

Behaviour:
- Reset:
  - state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - RAM contents are not reset.
  - Reset mid-operation discards the in-flight request.
  - A store not yet performed is never performed.
- States:
  - IDLE: req_ready = 1. On req_valid, capture we/addr/wdata/size/signed.
    - WAIT_CYCLES = 0: go to ACCESS.
    - Otherwise: load counter with WAIT_CYCLES and go to WAIT.
  - WAIT: req_ready = 0. Decrement the counter each cycle; at 1, go to ACCESS.
  - ACCESS: one cycle; req_ready = 0. Perform the RAM read or write, register the response, go to RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_err held stable. When resp_ready = 1, clear resp_valid and go to IDLE.
- Latency and throughput:
  - Accept at edge N; resp_valid first high after edge N+WAIT_CYCLES+1.
  - The earliest next accept is the cycle after the response handshake.
  - Maximum throughput: one request per WAIT_CYCLES+3 cycles.
- req_ready is combinational from state only; it never depends on req_valid.
- Error check, evaluated on captured fields:
  - size 3;
  - half with addr[0] != 0;
  - word with addr[1:0] != 0;
  - addr[31:ADDR_WIDTH+2] != 0.
  - On error: no RAM write, resp_rdata = 0, resp_err = 1.
- Addressing: word index = addr[ADDR_WIDTH+1:2]; lane = addr[1:0].
- Loads:
  - Byte = word[8*lane +: 8]; half = word[16*addr[1] +: 16].
  - Extend to 32 bits per req_signed. Word loads ignore req_signed.
- Stores:
  - Byte: write only byte lane addr[1:0] with wdata[7:0].
  - Half: write only lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0].
  - Word: write all lanes.
  - Unselected bytes are unchanged. Successful stores respond with rdata = 0, err = 0.
- Ordering: a load following a store to the same address returns the stored data; requests are fully serialised.
- req_valid during WAIT/ACCESS/RESP is ignored; the requester holds it until req_ready.

Test Plan:
- Word store/load, WAIT_CYCLES=1:
  - Store 0xDEADBEEF to 0x100, then load word from 0x100 → rdata 0xDEADBEEF, err 0.
  - resp_valid rises 2 cycles after the accept edge.
- Byte/half extension:
  - After the above, load byte 0x101 signed → 0xFFFFFFBE; unsigned → 0x000000BE.
  - Load half 0x102 signed → 0xFFFFDEAD.
- Partial store:
  - Store byte 0x55 to 0x103, then load word 0x100 → 0x55ADBEEF.
  - Store half 0x1234 to 0x100, then load word → 0x55AD1234.
- Errors, each returning err 1, rdata 0:
  - Half load at 0x101; word store at 0x102; size 3; address 0x00010000 (ADDR_WIDTH=12).
  - A subsequent load of the targeted words shows them unchanged.
- Backpressure:
  - Hold resp_ready = 0 for 5 cycles → resp_valid/rdata stable.
  - req_ready stays 0 while a second req_valid is held.
  - The second request is accepted the cycle after resp_ready = 1.
- Reset and WAIT_CYCLES=0:
  - Assert rst during WAIT of a store to 0x200 → outputs return to reset values; a later load of 0x200 returns the prior contents.
  - With WAIT_CYCLES=0, resp_valid is high one cycle after accept.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// accesses a word-organised RAM and returns extended load data or an error flag.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready depends only on state, and valid holds until accepted.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam int DEPTH = 1 << ADDR_WIDTH;

   state_t      state, state_nxt;
   logic [3:0]  wait_cnt;
   logic        cap_we, cap_signed;
   logic [31:0] cap_addr, cap_wdata;
   logic [1:0]  cap_size;

   logic [31:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            lane;
   logic                  acc_err;
   logic [31:0]           rd_word;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           load_data;
   logic [3:0]            byte_en;
   logic [31:0]           wdata_rep;

   assign dbg_state = state;

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt <= 4'd1) state_nxt = S_ACCESS;
         end
         S_ACCESS: state_nxt = S_RESP;
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Access datapath works entirely from the captured request fields.
   always_comb begin
      word_idx = cap_addr[ADDR_WIDTH+1:2];
      lane     = cap_addr[1:0];
      acc_err  = (cap_size == 2'd3)
               | ((cap_size == 2'd1) & cap_addr[0])
               | ((cap_size == 2'd2) & (|cap_addr[1:0]))
               | (|(cap_addr >> (ADDR_WIDTH + 2)));
      rd_word  = mem[word_idx];
      rd_byte  = rd_word[{lane, 3'b000} +: 8];
      rd_half  = rd_word[{cap_addr[1], 4'b0000} +: 16];
      case (cap_size)
         2'd0:    load_data = {{24{cap_signed & rd_byte[7]}}, rd_byte};
         2'd1:    load_data = {{16{cap_signed & rd_half[15]}}, rd_half};
         default: load_data = rd_word;
      endcase
      case (cap_size)
         2'd0: begin
            byte_en   = 4'b0001 << lane;
            wdata_rep = {4{cap_wdata[7:0]}};
         end
         2'd1: begin
            byte_en   = cap_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{cap_wdata[15:0]}};
         end
         2'd2: begin
            byte_en   = 4'b1111;
            wdata_rep = cap_wdata;
         end
         default: begin
            byte_en   = 4'b0000;
            wdata_rep = cap_wdata;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= 4'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         cap_we     <= 1'b0;
         cap_signed <= 1'b0;
         cap_addr   <= 32'd0;
         cap_wdata  <= 32'd0;
         cap_size   <= 2'd0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && req_valid) begin
            cap_we     <= req_we;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cap_size   <= req_size;
            cap_signed <= req_signed;
            wait_cnt   <= 4'(WAIT_CYCLES);
         end
         if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
         if (state == S_ACCESS) begin
            resp_rdata <= (acc_err || cap_we) ? 32'd0 : load_data;
            resp_err   <= acc_err;
         end
      end
   end

   // RAM is not reset; gating on rst drops a store caught by reset in ACCESS.
   always_ff @(posedge clk) begin
      if (!rst && state == S_ACCESS && cap_we && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed test-plan steps plus randomized traffic
// checked against a byte-addressed reference model.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [1:0]  dbg_state;

   logic        r0_valid, r0_ready, r0_we, r0_signed;
   logic [31:0] r0_addr, r0_wdata;
   logic [1:0]  r0_size;
   logic        p0_valid, p0_ready, p0_err;
   logic [31:0] p0_rdata;
   logic [1:0]  dbg_state0;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0] mem_m [0:16383];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_size(req_size), .req_signed(req_signed), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dbg_state(dbg_state)
   );

   dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(r0_valid), .req_ready(r0_ready),
      .req_we(r0_we), .req_addr(r0_addr), .req_wdata(r0_wdata),
      .req_size(r0_size), .req_signed(r0_signed), .resp_valid(p0_valid),
      .resp_ready(p0_ready), .resp_rdata(p0_rdata), .resp_err(p0_err),
      .dbg_state(dbg_state0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: memory as a flat byte array, little-endian.
   function automatic void model_op(input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [1:0] size,
                                    input logic sgn, output logic [31:0] rdata,
                                    output logic err);
      int n;
      logic [31:0] v;
      err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
            (size == 2'd2 && addr % 4 != 0) || (addr >= 32'h4000);
      rdata = 32'd0;
      if (err) return;
      n = 1 << size;
      if (we) begin
         for (int i = 0; i < n; i++) mem_m[addr + i] = 8'(wdata >> (8 * i));
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(mem_m[addr + i]) << (8 * i));
         if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
         rdata = v;
      end
   endfunction

   task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic sgn);
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_size   = size;
      req_signed = sgn;
      req_valid  = 1'b1;
   endtask

   task automatic wait_accept(input string tag);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_accept"}, req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                         input logic [31:0] exp_rd, input logic exp_err);
      int lat;
      drive_req(we, addr, wdata, size, sgn);
      wait_accept(tag);
      wait_resp(lat);
      check({tag, "_lat"}, lat, 2);
      check({tag, "_rdata"}, resp_rdata, exp_rd);
      check({tag, "_err"}, resp_err, exp_err);
      @(posedge clk); #1;
      check({tag, "_done"}, resp_valid, 1'b0);
   endtask

   // Directed step: model keeps memory in sync, expectations are spec constants.
   task automatic dir(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                      input logic [31:0] exp_rd, input logic exp_err);
      logic [31:0] mrd;
      logic        merr;
      model_op(we, addr, wdata, size, sgn, mrd, merr);
      do_req(tag, we, addr, wdata, size, sgn, exp_rd, exp_err);
   endtask

   task automatic rnd(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic sgn);
      logic [31:0] mrd;
      logic        merr;
      model_op(we, addr, wdata, size, sgn, mrd, merr);
      do_req(tag, we, addr, wdata, size, sgn, mrd, merr);
   endtask

   initial begin
      logic [31:0] mrd, addr;
      logic        merr;
      int          lat;
      logic [1:0]  sz;
      logic [31:0] w0_data [2];
      logic        w0_we [2];

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      req_size = 2'd0; req_signed = 1'b0; resp_ready = 1'b1;
      r0_valid = 1'b0; r0_we = 1'b0; r0_addr = 32'd0; r0_wdata = 32'd0;
      r0_size = 2'd0; r0_signed = 1'b0; p0_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", resp_err, 1'b0);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_state", dbg_state, 2'd0);

      // Word store/load and extension
      dir("st_word", 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 32'd0, 1'b0);
      dir("ld_word", 1'b0, 32'h100, 32'd0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
      dir("ld_b_s", 1'b0, 32'h101, 32'd0, 2'd0, 1'b1, 32'hFFFFFFBE, 1'b0);
      dir("ld_b_u", 1'b0, 32'h101, 32'd0, 2'd0, 1'b0, 32'h000000BE, 1'b0);
      dir("ld_h_s", 1'b0, 32'h102, 32'd0, 2'd1, 1'b1, 32'hFFFFDEAD, 1'b0);

      // Partial stores
      dir("st_byte", 1'b1, 32'h103, 32'hFFFFFF55, 2'd0, 1'b0, 32'd0, 1'b0);
      dir("ld_pb", 1'b0, 32'h100, 32'd0, 2'd2, 1'b0, 32'h55ADBEEF, 1'b0);
      dir("st_half", 1'b1, 32'h100, 32'hFFFF1234, 2'd1, 1'b0, 32'd0, 1'b0);
      dir("ld_ph", 1'b0, 32'h100, 32'd0, 2'd2, 1'b0, 32'h55AD1234, 1'b0);

      // Errors
      dir("st_w0", 1'b1, 32'h0, 32'h11223344, 2'd2, 1'b0, 32'd0, 1'b0);
      dir("e_half", 1'b0, 32'h101, 32'd0, 2'd1, 1'b1, 32'd0, 1'b1);
      dir("e_word", 1'b1, 32'h102, 32'hFFFFFFFF, 2'd2, 1'b0, 32'd0, 1'b1);
      dir("e_size3", 1'b1, 32'h100, 32'hFFFFFFFF, 2'd3, 1'b0, 32'd0, 1'b1);
      dir("e_range", 1'b1, 32'h00010000, 32'hFFFFFFFF, 2'd2, 1'b0, 32'd0, 1'b1);
      dir("e_chk100", 1'b0, 32'h100, 32'd0, 2'd2, 1'b0, 32'h55AD1234, 1'b0);
      dir("e_chk000", 1'b0, 32'h0, 32'd0, 2'd2, 1'b0, 32'h11223344, 1'b0);

      // Backpressure with a second request held pending
      resp_ready = 1'b0;
      model_op(1'b0, 32'h100, 32'd0, 2'd2, 1'b0, mrd, merr);
      drive_req(1'b0, 32'h100, 32'd0, 2'd2, 1'b0);
      wait_accept("bp1");
      wait_resp(lat);
      check("bp1_lat", lat, 2);
      drive_req(1'b0, 32'h0, 32'd0, 2'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp_valid%0d", i), resp_valid, 1'b1);
         check($sformatf("bp_rdata%0d", i), resp_rdata, 32'h55AD1234);
         check($sformatf("bp_ready%0d", i), req_ready, 1'b0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_hs_valid", resp_valid, 1'b0);
      check("bp_hs_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("bp2_taken", req_ready, 1'b0);
      model_op(1'b0, 32'h0, 32'd0, 2'd2, 1'b0, mrd, merr);
      wait_resp(lat);
      check("bp2_lat", lat, 2);
      check("bp2_rdata", resp_rdata, 32'h11223344);
      @(posedge clk); #1;

      // Reset during WAIT of a store
      dir("st_200", 1'b1, 32'h200, 32'hA5A5A5A5, 2'd2, 1'b0, 32'd0, 1'b0);
      dir("ld_200", 1'b0, 32'h200, 32'd0, 2'd2, 1'b0, 32'hA5A5A5A5, 1'b0);
      drive_req(1'b1, 32'h200, 32'h0BADF00D, 2'd2, 1'b0);
      wait_accept("abort");
      check("abort_in_wait", dbg_state, 2'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mrst_valid", resp_valid, 1'b0);
      check("mrst_rdata", resp_rdata, 32'd0);
      check("mrst_err", resp_err, 1'b0);
      check("mrst_ready", req_ready, 1'b1);
      dir("ld_200b", 1'b0, 32'h200, 32'd0, 2'd2, 1'b0, 32'hA5A5A5A5, 1'b0);

      // Zero-wait instance: response one cycle after accept
      w0_we[0] = 1'b1; w0_data[0] = 32'hCAFEF00D;
      w0_we[1] = 1'b0; w0_data[1] = 32'h0;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("w0_ready%0d", k), r0_ready, 1'b1);
         r0_we = w0_we[k]; r0_addr = 32'h40; r0_wdata = w0_data[k];
         r0_size = 2'd2; r0_signed = 1'b0; r0_valid = 1'b1;
         @(posedge clk); #1;
         r0_valid = 1'b0;
         check($sformatf("w0_early%0d", k), p0_valid, 1'b0);
         @(posedge clk); #1;
         check($sformatf("w0_valid%0d", k), p0_valid, 1'b1);
         check($sformatf("w0_rdata%0d", k), p0_rdata, w0_we[k] ? 32'd0 : 32'hCAFEF00D);
         check($sformatf("w0_err%0d", k), p0_err, 1'b0);
         @(posedge clk); #1;
         check($sformatf("w0_done%0d", k), p0_valid, 1'b0);
      end

      // Randomized traffic on a fully initialised region
      for (int i = 0; i < 64; i++)
         rnd($sformatf("init%0d", i), 1'b1, 32'(i * 4), $urandom, 2'd2, 1'b0);
      for (int i = 0; i < 80; i++) begin
         addr = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) addr = addr | 32'h0001_0000;
         sz = 2'($urandom_range(0, 3));
         rnd($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), addr, $urandom, sz,
             1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
